// File: rtl/fract_pkg.sv
// fract_pkg: shared definitions for the fractal scan core.
//   fract_state_t : scan FSM state encoding (IDLE, INIT, ITER, EMIT)
//   escape_r2()   : ESCAPE_R2 threshold (4.0 scaled by 2^frac), 2*ESC_MAX_W+1 bits;
//                   users slice it down to their own 2W+1 width
//   clog2()       : ceiling log2, used for counter sizing and ADDR_W checking
package fract_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_ITER = 2'd2,
        ST_EMIT = 2'd3
    } fract_state_t;

    // Widest coordinate word the escape threshold is prepared for.
    localparam int ESC_MAX_W = 64;

    function automatic logic [2*ESC_MAX_W:0] escape_r2(input int frac);
        logic [2*ESC_MAX_W:0] four;
        four = (2*ESC_MAX_W+1)'(4);
        return four << frac;
    endfunction

    function automatic int clog2(input longint value);
        int     result;
        longint v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            v      = v >> 1;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fract_iter_step.sv
// fract_iter_step: one combinational z = z^2 + c iteration in Q(W-FRAC).FRAC.
// Ports:
//   zr, zi           in  W  current z (two's complement)
//   cr, ci           in  W  constant c
//   zr_next, zi_next out W  next z; each product shifted right by FRAC, wrapped to W
//   escape           out 1  |z_next|^2 >= 4.0, evaluated at 2W+1 bits without wrap
module fract_iter_step
    import fract_pkg::*;
#(
    parameter int W    = 32,
    parameter int FRAC = 28
) (
    input  logic [W-1:0] zr,
    input  logic [W-1:0] zi,
    input  logic [W-1:0] cr,
    input  logic [W-1:0] ci,
    output logic [W-1:0] zr_next,
    output logic [W-1:0] zi_next,
    output logic         escape
);

    localparam logic [2*ESC_MAX_W:0] ESC_FULL  = escape_r2(FRAC);
    localparam logic [2*W:0]         ESCAPE_R2 = ESC_FULL[2*W:0];

    logic signed [2*W-1:0] zr_x, zi_x, nr_x, ni_x;
    logic signed [2*W-1:0] zr_sq, zi_sq, zr_zi, nr_sq, ni_sq;
    logic        [W-1:0]   zr_sq_t, zi_sq_t, zr_zi_t;
    logic        [2*W-1:0] nr_sq_sh, ni_sq_sh;
    logic        [2*W:0]   mag2;

    always_comb begin
        zr_x    = {{W{zr[W-1]}}, zr};
        zi_x    = {{W{zi[W-1]}}, zi};
        zr_sq   = zr_x * zr_x;
        zi_sq   = zi_x * zi_x;
        zr_zi   = zr_x * zi_x;
        zr_sq_t = W'(zr_sq >>> FRAC);
        zi_sq_t = W'(zi_sq >>> FRAC);
        zr_zi_t = W'(zr_zi >>> FRAC);
        zr_next = zr_sq_t - zi_sq_t + cr;
        zi_next = (zr_zi_t << 1) + ci;

        // Squares are non-negative, so keeping the full 2W shifted result and
        // adding one carry bit can never overflow.
        nr_x     = {{W{zr_next[W-1]}}, zr_next};
        ni_x     = {{W{zi_next[W-1]}}, zi_next};
        nr_sq    = nr_x * nr_x;
        ni_sq    = ni_x * ni_x;
        nr_sq_sh = nr_sq >>> FRAC;
        ni_sq_sh = ni_sq >>> FRAC;
        mag2     = {1'b0, nr_sq_sh} + {1'b0, ni_sq_sh};
        escape   = (mag2 >= ESCAPE_R2);
    end

endmodule

// File: rtl/fract_scan_core.sv
// fract_scan_core: scans an H_RES x V_RES frame, iterating z = z^2 + c once per
// clock per pixel, and writes an iteration-count colour per pixel to frame memory.
// Optional Julia mode is compiled in with the macro FRACT_JULIA_EN.
// Ports:
//   clk                      in   system clock
//   rst                      in   synchronous reset, active-low
//   start                    in   pulse: latch parameters and (re)start a frame
//   center_x, center_y, step in   W   frame centre and per-pixel delta
//   julia_mode/_cr/_ci       in   Julia selection and constant (FRACT_JULIA_EN only)
//   busy                     out  frame in progress
//   done                     out  one-cycle pulse after the last pixel is accepted
//   pix_valid, pix_ready     out/in  pixel write handshake
//   pix_addr                 out  ADDR_W   row*H_RES + col
//   pix_color                out  COLOR_W  0 for interior, else iteration count (never 0)
//
// state | meaning
// IDLE  | waiting for start
// INIT  | load z and c for the current pixel
// ITER  | one iteration per clock until escape or MAX_ITER
// EMIT  | present pixel, hold until accepted
module fract_scan_core
    import fract_pkg::*;
#(
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int W        = 32,
    parameter int FRAC     = 28,
    parameter int MAX_ITER = 255,
    parameter int COLOR_W  = 4,
    parameter int ADDR_W   = 19
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [W-1:0]       center_x,
    input  logic [W-1:0]       center_y,
    input  logic [W-1:0]       step,
`ifdef FRACT_JULIA_EN
    input  logic               julia_mode,
    input  logic [W-1:0]       julia_cr,
    input  logic [W-1:0]       julia_ci,
`endif
    output logic               busy,
    output logic               done,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [ADDR_W-1:0]  pix_addr,
    output logic [COLOR_W-1:0] pix_color
);

    localparam int PIX_COUNT = H_RES * V_RES;
    localparam int COL_W     = (clog2(H_RES) < 1) ? 1 : clog2(H_RES);
    localparam int ROW_W     = (clog2(V_RES) < 1) ? 1 : clog2(V_RES);
    localparam int ITER_W    = clog2(MAX_ITER + 1);

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(H_RES - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(V_RES - 1);
    localparam logic [ITER_W-1:0] ITER_CAP = ITER_W'(MAX_ITER);
    localparam logic [W-1:0]      HALF_H   = W'(H_RES / 2);
    localparam logic [W-1:0]      HALF_V   = W'(V_RES / 2);

    if (MAX_ITER < 1) begin : g_bad_iter
        $error("fract_scan_core: MAX_ITER must be at least 1");
    end
    if (ADDR_W < clog2(PIX_COUNT)) begin : g_bad_addr
        $error("fract_scan_core: ADDR_W too narrow for H_RES*V_RES");
    end

    fract_state_t state, state_nxt;

    logic               launch, accept, emit_load, done_nxt;
    logic               restart_req, last_pix, start_pend;
    logic [W-1:0]       pend_cx, pend_cy, pend_step;
    logic [W-1:0]       src_cx, src_cy, src_step;
    logic [W-1:0]       cr0_launch, ci0_launch;
    logic [W-1:0]       step_q, cr0_q, cr_pix, ci_pix;
    logic [W-1:0]       zr, zi, zr_next, zi_next;
    logic [W-1:0]       c_re, c_im, z0_re, z0_im;
    logic               escape;
    logic [ITER_W-1:0]  iter, iter_inc;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [COLOR_W-1:0] color_raw, color_nxt;

    // A start seen this cycle wins over an older pending one, so it always
    // takes the live inputs; otherwise the parameters captured earlier apply.
    assign src_cx   = start ? center_x : pend_cx;
    assign src_cy   = start ? center_y : pend_cy;
    assign src_step = start ? step     : pend_step;

    assign cr0_launch = src_cx - src_step * HALF_H;
    assign ci0_launch = src_cy - src_step * HALF_V;

`ifdef FRACT_JULIA_EN
    logic         pend_julia, julia_q, src_julia;
    logic [W-1:0] pend_jcr, pend_jci, jcr_q, jci_q, src_jcr, src_jci;

    assign src_julia = start ? julia_mode : pend_julia;
    assign src_jcr   = start ? julia_cr   : pend_jcr;
    assign src_jci   = start ? julia_ci   : pend_jci;

    assign c_re  = julia_q ? jcr_q  : cr_pix;
    assign c_im  = julia_q ? jci_q  : ci_pix;
    assign z0_re = julia_q ? cr_pix : '0;
    assign z0_im = julia_q ? ci_pix : '0;
`else
    assign c_re  = cr_pix;
    assign c_im  = ci_pix;
    assign z0_re = '0;
    assign z0_im = '0;
`endif

    fract_iter_step #(
        .W    (W),
        .FRAC (FRAC)
    ) u_iter_step (
        .zr      (zr),
        .zi      (zi),
        .cr      (c_re),
        .ci      (c_im),
        .zr_next (zr_next),
        .zi_next (zi_next),
        .escape  (escape)
    );

    assign restart_req = start || start_pend;
    assign last_pix    = (col == COL_LAST) && (row == ROW_LAST);
    assign iter_inc    = iter + ITER_W'(1);
    assign busy        = (state != ST_IDLE);
    assign pix_valid   = (state == ST_EMIT);

    always_comb begin
        color_raw = COLOR_W'(iter_inc);
        color_nxt = color_raw;
        if (iter_inc == ITER_CAP) begin
            color_nxt = '0;
        end else if (color_raw == '0) begin
            color_nxt = COLOR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        accept    = 1'b0;
        emit_load = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    launch    = 1'b1;
                    state_nxt = ST_INIT;
                end
            end
            ST_INIT: begin
                if (restart_req) begin
                    launch    = 1'b1;
                    state_nxt = ST_INIT;
                end else begin
                    state_nxt = ST_ITER;
                end
            end
            ST_ITER: begin
                if (restart_req) begin
                    launch    = 1'b1;
                    state_nxt = ST_INIT;
                end else if (escape || (iter_inc == ITER_CAP)) begin
                    emit_load = 1'b1;
                    state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                // A restart requested while presenting waits for this handshake
                // so the memory never sees a half-written transfer.
                if (pix_ready) begin
                    accept = 1'b1;
                    if (restart_req) begin
                        launch    = 1'b1;
                        state_nxt = ST_INIT;
                    end else if (last_pix) begin
                        done_nxt  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_INIT;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            done       <= 1'b0;
            start_pend <= 1'b0;
            pend_cx    <= '0;
            pend_cy    <= '0;
            pend_step  <= '0;
            step_q     <= '0;
            cr0_q      <= '0;
            cr_pix     <= '0;
            ci_pix     <= '0;
            zr         <= '0;
            zi         <= '0;
            iter       <= '0;
            col        <= '0;
            row        <= '0;
            pix_addr   <= '0;
            pix_color  <= '0;
`ifdef FRACT_JULIA_EN
            pend_julia <= 1'b0;
            pend_jcr   <= '0;
            pend_jci   <= '0;
            julia_q    <= 1'b0;
            jcr_q      <= '0;
            jci_q      <= '0;
`endif
        end else begin
            done <= done_nxt;

            if (start) begin
                pend_cx   <= center_x;
                pend_cy   <= center_y;
                pend_step <= step;
`ifdef FRACT_JULIA_EN
                pend_julia <= julia_mode;
                pend_jcr   <= julia_cr;
                pend_jci   <= julia_ci;
`endif
            end

            if (launch) begin
                start_pend <= 1'b0;
            end else if (start) begin
                start_pend <= 1'b1;
            end

            // Pixel coordinates advance by adding step, so no multiplier is
            // needed per pixel; cr0_q restores the line start on wrap.
            if (launch) begin
                step_q   <= src_step;
                cr0_q    <= cr0_launch;
                cr_pix   <= cr0_launch;
                ci_pix   <= ci0_launch;
                col      <= '0;
                row      <= '0;
                pix_addr <= '0;
`ifdef FRACT_JULIA_EN
                julia_q <= src_julia;
                jcr_q   <= src_jcr;
                jci_q   <= src_jci;
`endif
            end else if (accept && !last_pix) begin
                pix_addr <= pix_addr + ADDR_W'(1);
                if (col == COL_LAST) begin
                    col    <= '0;
                    row    <= row + ROW_W'(1);
                    cr_pix <= cr0_q;
                    ci_pix <= ci_pix + step_q;
                end else begin
                    col    <= col + COL_W'(1);
                    cr_pix <= cr_pix + step_q;
                end
            end

            if (state == ST_INIT) begin
                zr   <= z0_re;
                zi   <= z0_im;
                iter <= '0;
            end else if (state == ST_ITER) begin
                zr   <= zr_next;
                zi   <= zi_next;
                iter <= iter_inc;
            end

            if (emit_load) begin
                pix_color <= color_nxt;
            end
        end
    end

endmodule

// File: doc/fract_scan_core.md
Name: fract_scan_core

Overview:
- Parametrised successor to the fractal compute core.
- Scans a full H_RES x V_RES frame and iterates z = z^2 + c per pixel, one iteration per clock.
- Emits a COLOR_W-bit iteration-count colour per pixel over a valid/ready write port to the frame memory.
- The CPU-facing memory-mapped registers (pan X/Y, step) drive the inputs; start/busy/done replace free-running operation, and mid-frame restart is supported.

Parameters:
- H_RES, 640, pixels per line.
- V_RES, 480, lines per frame.
- W, 32, signed fixed-point word width of coordinates and z.
- FRAC, 28, fractional bits (Q(W-FRAC).FRAC).
- MAX_ITER, 255, iteration cap; must be >= 1.
- COLOR_W, 4, output colour width.
- ADDR_W, 19, pixel address width; must be >= clog2(H_RES*V_RES).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- start  in  1  one-cycle pulse: latch parameters and begin frame.
- center_x  in  W  real coordinate of frame centre.
- center_y  in  W  imaginary coordinate of frame centre.
- step  in  W  coordinate delta per pixel (zoom); must be non-negative.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after last pixel accepted.
- pix_valid  out  1  pixel result available.
- pix_ready  in  1  frame memory accepts pixel.
- pix_addr  out  ADDR_W  row*H_RES + col.
- pix_color  out  COLOR_W  pixel colour.

Behaviour:
- Reset (rst==0 at clk edge): state IDLE; busy, done, pix_valid = 0; pix_addr, pix_color = 0; all counters cleared. Takes priority over every other event, including mid-frame and mid-handshake.
- FSM states:
  - IDLE: on start, latch center_x/center_y/step. Compute cr0 = center_x - step*(H_RES/2) and ci0 = center_y - step*(V_RES/2), truncated to W bits. Go to INIT; busy = 1 from the next cycle.
  - INIT: cr = cr0 + col*step, ci = ci0 + row*step (maintained incrementally by adders, no multiplier). Set zr = zi = 0, iter = 0. Go to ITER.
  - ITER: each cycle, zr' = zr^2 - zi^2 + cr and zi' = 2*zr*zi + ci. Products are 2W wide, arithmetic-shifted right by FRAC, and truncated to W. iter increments. Escape when zr'^2 + zi'^2 >= 4.0, computed at 2W+1 bits with no truncation, or when iter reaches MAX_ITER. On escape, go to EMIT.
  - EMIT: pix_valid = 1. pix_color = 0 if iter == MAX_ITER, else iter mod 2^COLOR_W, forced to nonzero (0 maps to 1). pix_addr, pix_color and pix_valid stay stable until pix_valid && pix_ready. On the handshake:
    - last pixel: go to IDLE, pulse done, drop busy;
    - otherwise go to INIT.
- Scan order: col advances 0..H_RES-1, then wraps to 0 with row+1; pix_addr increments by 1 per accepted pixel.
- Latency per pixel: 1 (INIT) + iterations (1..MAX_ITER) + 1 minimum in EMIT.
- Restart: start while busy is recorded as pending.
  - In INIT/ITER: honoured at the next edge, abandoning the current pixel.
  - In EMIT: honoured only after the pending handshake completes.
  - A restart never produces done for the aborted frame. The new frame relatches parameters and begins at address 0.
- start with pix_ready held low has no other side effect. done and start in the same cycle: start wins and the new frame begins.

Optional Feature:
- Macro FRACT_JULIA_EN.
- When defined, adds ports julia_mode (in 1), julia_cr (in W), julia_ci (in W), all latched on start. With julia_mode = 1, z starts at the pixel coordinate and c = (julia_cr, julia_ci); with julia_mode = 0 behaviour is Mandelbrot.
- When undefined, the ports are absent and the core is Mandelbrot only, with identical timing.

Decomposition:
- Shared package fract_pkg holds:
  - FSM state encoding (IDLE, INIT, ITER, EMIT);
  - ESCAPE_R2 constant (4 << FRAC, 2W+1 bits);
  - clog2 helper for ADDR_W checking.
- One natural sub-module: fract_iter_step. It is combinational: inputs zr, zi, cr, ci; outputs zr_next, zi_next, escape. Parametrised by W and FRAC.

Test Plan:
All scenarios use the bench configuration H_RES=4, V_RES=2, W=16, FRAC=12, MAX_ITER=15, COLOR_W=4 unless stated.
- Reset: hold rst=0 for 3 cycles, with start=1 -> busy, done, pix_valid, pix_addr, pix_color all 0.
- Interior frame: center 0,0, step 0, start, pix_ready=1 -> 8 pixels at addr 0..7, each color 0, each 17 cycles apart; done pulses once; busy falls with it.
- Immediate escape: center_x=0x2000 (2.0), center_y=0, step 0 -> every pixel color 1, 3 cycles per pixel.
- Backpressure: pix_ready=0 for 10 cycles during first EMIT -> pix_valid=1, pix_addr=0, pix_color unchanged throughout; accepted on the cycle ready rises; next pixel addr 1.
- Restart: start again during ITER of addr 3 -> no pixel at addr 3 from the old frame, no done; new frame emits addr 0..7 and one done.
- Reset mid-frame: rst=0 during EMIT with pix_ready=0 -> next cycle pix_valid=0 and busy=0; no done.
